// File: rtl/e_mdu_pkg.sv
// Shared definitions for the execute-stage multiply/divide unit:
// op encodings, default latencies and counter width.
package e_mdu_pkg;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } md_op_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } mdu_state_e;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;
  localparam int CNT_W           = 4;

endpackage

// File: rtl/e_mdu.sv
// Multi-cycle multiply/divide unit holding the HI/LO registers; results are
// computed at issue and committed after a fixed latency, with busy exposed for stalls.
module e_mdu
  import e_mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic        req,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  mdu_state_e        state, state_next;
  logic [CNT_W-1:0]  cnt;
  logic [31:0]       hi_tmp, lo_tmp;
  logic              commit_ok;

  logic              is_mult, is_div, start_op;
  logic signed [63:0] sprod;
  logic [63:0]       uprod;
  logic [31:0]       squot, srem, uquot, urem;
  logic [31:0]       res_hi, res_lo;

  assign busy = (state == S_BUSY);

  always_comb begin
    is_mult  = (md_op == MD_MULT) || (md_op == MD_MULTU);
    is_div   = (md_op == MD_DIV)  || (md_op == MD_DIVU);
    start_op = start && !req && (is_mult || is_div) && (state == S_IDLE);

    sprod = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    uprod = {32'd0, A} * {32'd0, B};

    squot = 32'd0;
    srem  = 32'd0;
    uquot = 32'd0;
    urem  = 32'd0;
    // Zero divisor and the INT_MIN/-1 overflow case are kept away from the operators.
    if (B != 32'd0) begin
      uquot = A / B;
      urem  = A % B;
      if (A == 32'h8000_0000 && B == 32'hFFFF_FFFF) begin
        squot = A;
        srem  = 32'd0;
      end else begin
        squot = $signed(A) / $signed(B);
        srem  = $signed(A) % $signed(B);
      end
    end

    res_hi = 32'd0;
    res_lo = 32'd0;
    case (md_op)
      MD_MULT:  begin res_hi = sprod[63:32]; res_lo = sprod[31:0]; end
      MD_MULTU: begin res_hi = uprod[63:32]; res_lo = uprod[31:0]; end
      MD_DIV:   begin res_hi = srem;         res_lo = squot;       end
      MD_DIVU:  begin res_hi = urem;         res_lo = uquot;       end
      default:  ;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (start_op) state_next = S_BUSY;
      S_BUSY: if (cnt == CNT_W'(1)) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_next;
  end

  // Results are latched at issue; the countdown only decides when they become visible.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt       <= '0;
      hi_tmp    <= '0;
      lo_tmp    <= '0;
      commit_ok <= 1'b0;
      HI        <= '0;
      LO        <= '0;
    end else if (state == S_IDLE) begin
      if (start_op) begin
        cnt       <= is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        hi_tmp    <= res_hi;
        lo_tmp    <= res_lo;
        commit_ok <= !(is_div && (B == 32'd0));
      end else if (!req && md_op == MD_MTHI) begin
        HI <= A;
      end else if (!req && md_op == MD_MTLO) begin
        LO <= A;
      end
    end else begin
      cnt <= cnt - CNT_W'(1);
      if (cnt == CNT_W'(1)) begin
        commit_ok <= 1'b0;
        if (commit_ok) begin
          HI <= hi_tmp;
          LO <= lo_tmp;
        end
      end
    end
  end

endmodule
